// File: rtl/ladder_arbiter.sv
// ladder_arbiter: round-robin grant of a shared ladder-count engine.
// A granted requester's delta is latched, then count climbs 0..delta,
// falls back to 0, and a one-cycle done pulse reports which requester finished.
module ladder_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 3,
  parameter int CW    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_delta,
  output logic [N_REQ-1:0]           req_ready,
  output logic [CW-1:0]              count,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [DW-1:0]    s_delta_reg, s_delta_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;

  logic [DW-1:0]    delta_arr [N_REQ];
  logic             grant_found;
  logic [IW-1:0]    grant_idx;

  // The count register must be able to hold the largest delta.
  generate
    if (CW < DW) begin : g_width_check
      $error("ladder_arbiter: CW must be >= DW");
    end
  endgenerate

  // Unpack the flat delta bus into one field per requester.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_delta
      assign delta_arr[gi] = req_delta[gi*DW +: DW];
    end
  endgenerate

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      automatic int idx = (int'(rr_ptr_reg) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  // Next-state logic: grant in IDLE, then climb, descend and report.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    s_delta_next = s_delta_reg;
    owner_next   = owner_reg;
    rr_ptr_next  = rr_ptr_reg;
    req_ready    = '0;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          s_delta_next         = delta_arr[grant_idx];
          owner_next           = grant_idx;
          rr_ptr_next          = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          count_next           = '0;
          state_next           = (delta_arr[grant_idx] == '0) ? DONE : UP;
        end
      end
      UP: begin
        if (count_reg != CW'(s_delta_reg)) begin
          count_next = count_reg + 1'b1;
        end else begin
          // Peak reached: start descending; a peak of 1 lands on 0 directly.
          count_next = count_reg - 1'b1;
          state_next = (s_delta_reg == DW'(1)) ? DONE : DOWN;
        end
      end
      DOWN: begin
        count_next = count_reg - 1'b1;
        if (count_reg == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        count_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      s_delta_reg <= '0;
      owner_reg   <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      s_delta_reg <= s_delta_next;
      owner_reg   <= owner_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  assign count   = count_reg;
  assign busy    = (state_reg != IDLE);
  assign owner   = owner_reg;
  assign done_id = done ? owner_reg : '0;

endmodule

// File: tb/tb_ladder_arbiter.sv
// Testbench for ladder_arbiter: vector table of single grants plus
// hand-written sequences, with a per-cycle scoreboard of the ladder.
module tb_ladder_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [11:0] req_delta;
  logic [3:0]  req_ready;
  logic [3:0]  count;
  logic        busy;
  logic [1:0]  owner;
  logic        done;
  logic [1:0]  done_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int count;
    bit busy;
    bit done;
    int did;
    int owner;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] delta;
    int          grant;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  ladder_arbiter #(.N_REQ(4), .DW(3), .CW(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_delta(req_delta),
    .req_ready(req_ready), .count(count), .busy(busy), .owner(owner),
    .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s = %0d (t=%0t)", name, act, $time);
    end
  endtask

  // Expected per-cycle ladder for a run of peak d owned by requester g.
  task automatic push_run(input int d, input int g);
    int last;
    exp_t e;
    last = (d == 0) ? 0 : 2 * d;
    for (int c = 0; c <= last; c++) begin
      e.count = (c <= d) ? c : 2 * d - c;
      e.busy  = 1'b1;
      e.done  = (c == last);
      e.did   = g;
      e.owner = g;
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: one popped record per cycle after the transfer edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_count", int'(count), e.count);
        chk("sb_busy", int'(busy), int'(e.busy));
        chk("sb_done", int'(done), int'(e.done));
        chk("sb_owner", int'(owner), e.owner);
        chk("sb_ready_zero", int'(req_ready), 0);
        if (e.done) chk("sb_done_id", int'(done_id), e.did);
      end else begin
        chk("idle_no_done", int'(done), 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  // One grant from the table: check the one-hot grant, scoreboard the run,
  // and scramble the deltas mid-run to show they are not re-sampled.
  task automatic run_vec(input logic [3:0] v, input logic [11:0] dl, input int g);
    logic [11:0] dtmp;
    int d;
    @(negedge clk);
    req_valid = v;
    req_delta = dl;
    #1;
    chk("grant_onehot", int'(req_ready), 1 << g);
    dtmp = dl >> (3 * g);
    d = int'(dtmp[2:0]);
    push_run(d, g);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    req_delta = 12'($urandom);
    wait_drain();
  endtask

  initial begin
    int order[5];
    int last_cyc;
    int t;
    order = '{0, 1, 2, 3, 0};
    vecs[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 0};
    vecs[1] = '{4'b0100, {3'd5, 3'd0, 3'd6, 3'd4}, 2};
    vecs[2] = '{4'b0010, {3'd2, 3'd3, 3'd7, 3'd1}, 1};
    vecs[3] = '{4'b1011, {3'd2, 3'd6, 3'd4, 3'd5}, 3};
    vecs[4] = '{4'b1010, {3'd1, 3'd0, 3'd3, 3'd7}, 1};
    vecs[5] = '{4'b0011, {3'd4, 3'd4, 3'd2, 3'd1}, 0};

    reset = 1'b1;
    req_valid = '0;
    req_delta = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_ready", int'(req_ready), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Table: single grants, zero delta, max delta, wrap-around search.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i].valid, vecs[i].delta, vecs[i].grant);
    end

    // Held requests from all four, d=1: order 0,1,2,3,0 at 4-cycle spacing.
    do_reset();
    @(negedge clk);
    req_valid = 4'hF;
    req_delta = {3'd1, 3'd1, 3'd1, 3'd1};
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      t = 0;
      while (req_ready == '0 && t < 40) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("rr_order", int'(req_ready), 1 << order[k]);
      if (k > 0) chk("rr_spacing", cyc - last_cyc, 4);
      last_cyc = cyc;
      push_run(1, order[k]);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    wait_drain();

    // Requester 3 alone from rr_ptr=0, then rr_ptr must have wrapped to 0.
    do_reset();
    run_vec(4'b1000, {3'd2, 3'd0, 3'd0, 3'd0}, 3);
    run_vec(4'b1111, {3'd1, 3'd1, 3'd1, 3'd2}, 0);

    // Reset mid-run at count=3 of a d=5 ladder: no done may follow.
    @(negedge clk);
    req_valid = 4'b0001;
    req_delta = {3'd0, 3'd0, 3'd0, 3'd5};
    #1;
    chk("mid_grant", int'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("mid_count3", int'(count), 3);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_after_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
